mf_coeff_receiver: RTL and testbench
====================================

Name: mf_coeff_receiver

Overview:
- Receiving end of the coefficient stream that the MIF reader produces.
- Requests samples from the source, time-reverses and conjugates them into matched-filter form, and stores them in an internal coefficient bank.
- Signals when the bank is complete and serves it to the complex FIR through a registered random-access read port.
- Sits between the coefficient MIF reader and n_tap_complex_fir inside the matched filter top.

Parameters:
LENGTH, 10000, number of complex coefficients stored
DATA_WIDTH, 16, signed width of each real/imag part
REVERSE, 1, 1 = store sample k at address LENGTH-1-k; 0 = store at k
CONJUGATE, 1, 1 = negate the imaginary part before storing; 0 = store unchanged
ADDR_WIDTH, $clog2(LENGTH), read address width

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle request to (re)load the bank
sourceEnable  out  1  drives the MIF reader enable
sourceValid  in  1  coeffInRe/Im hold a valid sample this cycle
sourceFinished  in  1  source has delivered its last sample
coeffInRe  in  DATA_WIDTH  signed real sample
coeffInIm  in  DATA_WIDTH  signed imaginary sample
busy  out  1  load in progress
coefficientsSetFlag  out  1  bank holds exactly LENGTH valid coefficients
underrunError  out  1  source finished before LENGTH samples were received
readEn  in  1  read strobe
readAddr  in  ADDR_WIDTH  read address
coeffOutRe  out  DATA_WIDTH  registered read data, real part
coeffOutIm  out  DATA_WIDTH  registered read data, imaginary part

Behaviour:
- Reset values: state IDLE; sourceEnable, busy, coefficientsSetFlag, underrunError, coeffOutRe and coeffOutIm all 0; sample counter 0.
- Bank memory is not cleared by reset.
- Reset asserted mid-load aborts the load at that edge. sourceEnable is low from the following cycle.
- States are IDLE, LOAD, DONE, ERROR.
- IDLE:
  - start -> LOAD.
  - On entry to LOAD: counter cleared, coefficientsSetFlag and underrunError cleared.
- LOAD:
  - sourceEnable = 1 and busy = 1.
  - On each cycle with sourceValid = 1, write the bank at addr = REVERSE ? LENGTH-1-count : count, then increment count.
  - Re is stored unchanged.
  - Im is stored as -Im when CONJUGATE = 1, with saturation: -(-2^(DATA_WIDTH-1)) stores as 2^(DATA_WIDTH-1)-1.
  - When the accepted sample is the LENGTH-th one -> DONE. sourceEnable is low the next cycle.
  - sourceFinished with count (including any sample accepted in the same cycle) < LENGTH -> ERROR.
  - sourceFinished on the same cycle as the LENGTH-th valid sample -> DONE, not ERROR.
  - start during LOAD is ignored.
- DONE:
  - coefficientsSetFlag = 1, held; sourceEnable = 0.
  - sourceValid and sourceFinished are ignored.
  - start -> LOAD, which clears the flag on the next cycle.
- ERROR:
  - underrunError = 1, held; coefficientsSetFlag = 0; sourceEnable = 0.
  - start -> LOAD; reset -> IDLE.
- Read port:
  - Active in every state.
  - readEn at cycle t -> coeffOutRe/Im valid at cycle t+1.
  - readAddr >= LENGTH returns 0.
  - Outputs hold their last value when readEn = 0.
  - Read and write to the same address in the same cycle return the old contents.
  - Consumers must qualify reads with coefficientsSetFlag.
- Throughput: one sample per clock, no back-pressure. The source may insert idle cycles (sourceValid = 0) freely.

Test Plan:
- LENGTH=8, REVERSE=1, CONJUGATE=1, start, then 8 back-to-back samples Re=k+1, Im=10*(k+1) -> coefficientsSetFlag high the cycle after sample 8. Reading addr 0 gives Re=8, Im=-80; addr 7 gives Re=1, Im=-10.
- Same setup with sourceValid gapped (valid every other cycle) -> identical bank contents. sourceEnable stays high for 16 cycles.
- Sample with Im=-32768 (DATA_WIDTH=16) -> stored Im=32767. Im=32767 -> stored -32767.
- sourceFinished asserted after 5 samples -> underrunError=1, coefficientsSetFlag=0, sourceEnable=0. A following start plus 8 samples -> flag=1, error=0.
- Reset asserted after sample 3 -> the next cycle has sourceEnable=0, busy=0, flag=0. Later samples are not written: an addr-4 read returns its pre-reset contents.
- Read with readAddr=9 at LENGTH=8 -> coeffOutRe/Im=0 the following cycle. A 9th sourceValid in DONE leaves the bank unchanged.

Source files
------------

// File: rtl/mf_coeff_receiver.sv
// Coefficient bank loader for the matched filter: takes the MIF reader stream,
// time-reverses and conjugates it, and serves the bank through a registered read port.
module mf_coeff_receiver #(
  parameter int LENGTH     = 10000,
  parameter int DATA_WIDTH = 16,
  parameter bit REVERSE    = 1'b1,
  parameter bit CONJUGATE  = 1'b1,
  parameter int ADDR_WIDTH = $clog2(LENGTH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  output logic                         sourceEnable,
  input  logic                         sourceValid,
  input  logic                         sourceFinished,
  input  logic signed [DATA_WIDTH-1:0] coeffInRe,
  input  logic signed [DATA_WIDTH-1:0] coeffInIm,
  output logic                         busy,
  output logic                         coefficientsSetFlag,
  output logic                         underrunError,
  input  logic                         readEn,
  input  logic [ADDR_WIDTH-1:0]        readAddr,
  output logic signed [DATA_WIDTH-1:0] coeffOutRe,
  output logic signed [DATA_WIDTH-1:0] coeffOutIm
);

  // state   | meaning
  // IDLE    | waiting for the first start after reset
  // LOAD    | source enabled, accepting samples into the bank
  // DONE    | bank holds LENGTH coefficients, flag raised
  // ERROR   | source finished early, underrun raised
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int CNT_W = $clog2(LENGTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LENGTH - 1);
  localparam logic signed [DATA_WIDTH-1:0] D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] D_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  logic [1:0]                  r_state;
  logic [CNT_W-1:0]            r_count;
  logic signed [DATA_WIDTH-1:0] r_bank_re [0:LENGTH-1];
  logic signed [DATA_WIDTH-1:0] r_bank_im [0:LENGTH-1];
  logic signed [DATA_WIDTH-1:0] r_out_re;
  logic signed [DATA_WIDTH-1:0] r_out_im;

  logic                        w_accept;
  logic                        w_last;
  logic [CNT_W-1:0]            w_wr_pos;
  logic [IDX_W-1:0]            w_wr_idx;
  logic [IDX_W-1:0]            w_rd_idx;
  logic                        w_rd_oob;
  logic signed [DATA_WIDTH-1:0] w_im_store;

  assign w_accept = (r_state == S_LOAD) && sourceValid;
  assign w_last   = w_accept && (r_count == LAST_CNT);
  assign w_wr_pos = REVERSE ? (LAST_CNT - r_count) : r_count;
  assign w_wr_idx = IDX_W'(w_wr_pos);
  assign w_rd_idx = IDX_W'(readAddr);
  assign w_rd_oob = (32'(readAddr) >= 32'(LENGTH));

  // Negating the most negative value would wrap, so it saturates to the max.
  assign w_im_store = !CONJUGATE ? coeffInIm :
                      (coeffInIm == D_MIN) ? D_MAX : -coeffInIm;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_state <= S_LOAD;
            r_count <= '0;
          end
        end
        S_LOAD: begin
          if (w_accept) r_count <= r_count + 1'b1;
          if (w_last) r_state <= S_DONE;
          else if (sourceFinished) r_state <= S_ERROR;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bank contents survive reset; only the write strobe is blocked by it.
  always_ff @(posedge clock) begin
    if (w_accept && !reset) begin
      r_bank_re[w_wr_idx] <= coeffInRe;
      r_bank_im[w_wr_idx] <= w_im_store;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_re <= '0;
      r_out_im <= '0;
    end else if (readEn) begin
      if (w_rd_oob) begin
        r_out_re <= '0;
        r_out_im <= '0;
      end else begin
        r_out_re <= r_bank_re[w_rd_idx];
        r_out_im <= r_bank_im[w_rd_idx];
      end
    end
  end

  assign sourceEnable        = (r_state == S_LOAD);
  assign busy                = (r_state == S_LOAD);
  assign coefficientsSetFlag = (r_state == S_DONE);
  assign underrunError       = (r_state == S_ERROR);
  assign coeffOutRe          = r_out_re;
  assign coeffOutIm          = r_out_im;

endmodule

// File: tb/tb_mf_coeff_receiver.sv
// Randomized bench for mf_coeff_receiver at LENGTH=8 with a reversed/conjugated bank model.
module tb_mf_coeff_receiver;
  localparam int LEN = 8;
  localparam int DW  = 16;
  localparam int AW  = 4;

  logic clock = 1'b0;
  logic reset, start, sourceValid, sourceFinished, readEn;
  logic signed [DW-1:0] coeffInRe, coeffInIm, coeffOutRe, coeffOutIm;
  logic [AW-1:0] readAddr;
  logic sourceEnable, busy, coefficientsSetFlag, underrunError;

  int n_cmp = 0;
  int n_bad = 0;
  int m_re [LEN];
  int m_im [LEN];
  int q_re [$];
  int q_im [$];
  int en_cyc;
  int last_re, last_im;

  mf_coeff_receiver #(
    .LENGTH(LEN), .DATA_WIDTH(DW), .REVERSE(1'b1), .CONJUGATE(1'b1), .ADDR_WIDTH(AW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .sourceEnable(sourceEnable),
    .sourceValid(sourceValid), .sourceFinished(sourceFinished),
    .coeffInRe(coeffInRe), .coeffInIm(coeffInIm), .busy(busy),
    .coefficientsSetFlag(coefficientsSetFlag), .underrunError(underrunError),
    .readEn(readEn), .readAddr(readAddr), .coeffOutRe(coeffOutRe), .coeffOutIm(coeffOutIm)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Sample k of a load lands at LEN-1-k with its imaginary part negated and clipped.
  task automatic model_store(input int k, input int re, input int im);
    int neg;
    neg = -im;
    if (neg > 32767) neg = 32767;
    m_re[LEN-1-k] = re;
    m_im[LEN-1-k] = neg;
  endtask

  task automatic gen_random(input int n);
    q_re.delete();
    q_im.delete();
    for (int i = 0; i < n; i++) begin
      q_re.push_back(int'($urandom_range(0, 65535)) - 32768);
      q_im.push_back(int'($urandom_range(0, 65535)) - 32768);
    end
  endtask

  task automatic begin_load();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid on odd cycles with a stray start, 2: random gaps
  task automatic feed(input int mode, input int n, output int en_count);
    int k;
    bit v;
    k = 0;
    en_count = 0;
    for (int c = 0; c < 64 && k < n; c++) begin
      if (sourceEnable) en_count++;
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 1) : 1'($urandom_range(0, 1));
      start = (mode == 1) && (c == 4);
      sourceValid = v;
      if (v) begin
        coeffInRe = 16'(q_re[k]);
        coeffInIm = 16'(q_im[k]);
        model_store(k, q_re[k], q_im[k]);
        k++;
      end else begin
        coeffInRe = 16'($urandom);
        coeffInIm = 16'($urandom);
      end
      step();
    end
    sourceValid = 1'b0;
    start = 1'b0;
    check("feed_budget", k, n);
  endtask

  task automatic rd_check(input int a);
    int er, ei;
    readAddr = AW'(a);
    readEn = 1'b1;
    step();
    readEn = 1'b0;
    er = (a < LEN) ? m_re[a] : 0;
    ei = (a < LEN) ? m_im[a] : 0;
    check($sformatf("rd_re[%0d]", a), coeffOutRe, er);
    check($sformatf("rd_im[%0d]", a), coeffOutIm, ei);
    last_re = er;
    last_im = ei;
  endtask

  task automatic rd_all();
    for (int a = 0; a < LEN; a++) rd_check(a);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sourceValid = 1'b0; sourceFinished = 1'b0;
    readEn = 1'b0; readAddr = '0; coeffInRe = '0; coeffInIm = '0;
    step();
    step();
    check("rst_enable", sourceEnable, 0);
    check("rst_busy", busy, 0);
    check("rst_flag", coefficientsSetFlag, 0);
    check("rst_err", underrunError, 0);
    check("rst_out_re", coeffOutRe, 0);
    check("rst_out_im", coeffOutIm, 0);
    reset = 1'b0;
    step();

    // Ramp load: Re=k+1, Im=10*(k+1)
    q_re.delete();
    q_im.delete();
    for (int k = 0; k < LEN; k++) begin
      q_re.push_back(k + 1);
      q_im.push_back(10 * (k + 1));
    end
    begin_load();
    check("t1_busy", busy, 1);
    check("t1_enable", sourceEnable, 1);
    feed(0, LEN, en_cyc);
    check("t1_en_cycles", en_cyc, 8);
    check("t1_flag", coefficientsSetFlag, 1);
    check("t1_enable_off", sourceEnable, 0);
    check("t1_err", underrunError, 0);
    rd_check(0);
    check("t1_a0_re", coeffOutRe, 8);
    check("t1_a0_im", coeffOutIm, -80);
    rd_check(7);
    check("t1_a7_re", coeffOutRe, 1);
    check("t1_a7_im", coeffOutIm, -10);

    // Gapped random load with saturation corner values
    gen_random(LEN);
    q_im[2] = -32768;
    q_im[5] = 32767;
    begin_load();
    check("t2_flag_cleared", coefficientsSetFlag, 0);
    feed(1, LEN, en_cyc);
    check("t2_en_cycles", en_cyc, 16);
    check("t2_flag", coefficientsSetFlag, 1);
    rd_all();
    rd_check(5);
    check("t2_sat_min", coeffOutIm, 32767);
    rd_check(2);
    check("t2_sat_max", coeffOutIm, -32767);

    // Read port holds while readEn is low
    readAddr = AW'($urandom_range(0, 7));
    step();
    step();
    check("hold_re", coeffOutRe, last_re);
    check("hold_im", coeffOutIm, last_im);

    rd_check(9);
    rd_check(15);

    // Source activity in DONE must not touch the bank
    sourceValid = 1'b1;
    sourceFinished = 1'b1;
    for (int i = 0; i < 3; i++) begin
      coeffInRe = 16'($urandom);
      coeffInIm = 16'($urandom);
      step();
    end
    sourceValid = 1'b0;
    sourceFinished = 1'b0;
    check("done_flag_held", coefficientsSetFlag, 1);
    check("done_no_err", underrunError, 0);
    rd_all();

    // Underrun after 5 samples, then recovery
    gen_random(LEN);
    begin_load();
    feed(0, 5, en_cyc);
    sourceFinished = 1'b1;
    step();
    sourceFinished = 1'b0;
    check("ur_err", underrunError, 1);
    check("ur_flag", coefficientsSetFlag, 0);
    check("ur_enable", sourceEnable, 0);
    check("ur_busy", busy, 0);
    step();
    check("ur_err_held", underrunError, 1);
    gen_random(LEN);
    begin_load();
    check("ur_err_cleared", underrunError, 0);
    feed(0, LEN, en_cyc);
    check("ur_recover_flag", coefficientsSetFlag, 1);
    check("ur_recover_err", underrunError, 0);
    rd_all();

    // Reset after sample 3 aborts the load; later samples are dropped
    gen_random(LEN);
    begin_load();
    feed(0, 3, en_cyc);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mr_enable", sourceEnable, 0);
    check("mr_busy", busy, 0);
    check("mr_flag", coefficientsSetFlag, 0);
    sourceValid = 1'b1;
    for (int k = 3; k < LEN; k++) begin
      coeffInRe = 16'(q_re[k]);
      coeffInIm = 16'(q_im[k]);
      step();
    end
    sourceValid = 1'b0;
    rd_check(4);
    rd_all();

    // Random-gap loads
    for (int it = 0; it < 3; it++) begin
      gen_random(LEN);
      begin_load();
      feed(2, LEN, en_cyc);
      check("rnd_flag", coefficientsSetFlag, 1);
      rd_all();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
